// File: rtl/a_diag_read_arbiter.sv
// Round-robin read arbiter for the A-diagonal element memory: grants one engine per cycle,
// drives the memory read port and steers returning elements back through a tag pipeline.
module a_diag_read_arbiter #(
   parameter int NUM_REQ       = 4,
   parameter int ROW_WIDTH     = 6,
   parameter int NUM_ROWS      = 64,
   parameter int ELEMENT_WIDTH = 32,
   parameter int MEM_LATENCY   = 1
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           enable,
   input  logic [NUM_REQ-1:0]             req,
   input  logic [NUM_REQ*ROW_WIDTH-1:0]   req_row,
   output logic [NUM_REQ-1:0]             gnt,
   output logic [NUM_REQ-1:0]             rsp_valid,
   output logic [ELEMENT_WIDTH-1:0]       rsp_data,
   output logic                           rsp_err,
   output logic                           mem_rd_en,
   output logic [ROW_WIDTH-1:0]           mem_addr,
   input  logic [ELEMENT_WIDTH-1:0]       mem_rd_data,
   output logic                           idle
);

   localparam int ID_W = $clog2(NUM_REQ);
   localparam int LAST = MEM_LATENCY - 1;

   logic [ID_W-1:0]      ptr;
   logic [NUM_REQ-1:0]   elig;
   logic                 found;
   logic [ID_W-1:0]      sel;
   logic [ROW_WIDTH-1:0] sel_row;
   logic                 row_ok;

   logic [ID_W-1:0]      gnt_id_p0;
   logic                 gnt_err_p0;

   logic [MEM_LATENCY-1:0]           tag_vld_p1;
   logic [MEM_LATENCY-1:0][ID_W-1:0] tag_id_p1;
   logic [MEM_LATENCY-1:0]           tag_err_p1;

   function automatic logic [NUM_REQ-1:0] onehot(input logic [ID_W-1:0] id);
      logic [NUM_REQ-1:0] oh;
      oh = '0;
      for (int i = 0; i < NUM_REQ; i++) oh[i] = (id == ID_W'(i));
      return oh;
   endfunction

   // The requester just granted is masked so nobody wins two cycles in a row.
   assign elig = req & ~gnt;

   always_comb begin
      int j;
      j       = 0;
      found   = 1'b0;
      sel     = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         j = int'(ptr) + i;
         if (j >= NUM_REQ) j = j - NUM_REQ;
         if (!found && elig[ID_W'(j)]) begin
            found = 1'b1;
            sel   = ID_W'(j);
         end
      end
      sel_row = req_row[int'(sel)*ROW_WIDTH +: ROW_WIDTH];
      row_ok  = int'(sel_row) < NUM_ROWS;
   end

   // Stage p0: grant and memory request
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr        <= '0;
         gnt        <= '0;
         gnt_id_p0  <= '0;
         gnt_err_p0 <= 1'b0;
         mem_rd_en  <= 1'b0;
         mem_addr   <= '0;
      end else if (enable && found) begin
         gnt        <= onehot(sel);
         ptr        <= (sel == ID_W'(NUM_REQ-1)) ? '0 : sel + 1'b1;
         gnt_id_p0  <= sel;
         gnt_err_p0 <= ~row_ok;
         mem_rd_en  <= row_ok;
         if (row_ok) mem_addr <= sel_row;
      end else begin
         gnt        <= '0;
         gnt_err_p0 <= 1'b0;
         mem_rd_en  <= 1'b0;
      end
   end

   // Stage p1: tag pipeline tracking reads in flight
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tag_vld_p1 <= '0;
         tag_id_p1  <= '0;
         tag_err_p1 <= '0;
      end else begin
         tag_vld_p1[0] <= |gnt;
         tag_id_p1[0]  <= gnt_id_p0;
         tag_err_p1[0] <= gnt_err_p0;
         for (int s = 1; s < MEM_LATENCY; s++) begin
            tag_vld_p1[s] <= tag_vld_p1[s-1];
            tag_id_p1[s]  <= tag_id_p1[s-1];
            tag_err_p1[s] <= tag_err_p1[s-1];
         end
      end
   end

   // Stage p2: response register, aligned with memory data
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rsp_valid <= '0;
         rsp_data  <= '0;
         rsp_err   <= 1'b0;
      end else if (tag_vld_p1[LAST]) begin
         rsp_valid <= onehot(tag_id_p1[LAST]);
         rsp_data  <= tag_err_p1[LAST] ? '0 : mem_rd_data;
         rsp_err   <= tag_err_p1[LAST];
      end else begin
         rsp_valid <= '0;
         rsp_err   <= 1'b0;
      end
   end

   assign idle = ~|gnt & ~|tag_vld_p1 & ~|rsp_valid;

endmodule

// File: tb/tb_a_diag_read_arbiter.sv
// Directed bench for a_diag_read_arbiter: 4 requesters, 7-bit rows (so row 64 is expressible),
// a 1-cycle behavioural diagonal memory holding 32'h3F800000+i.
module tb_a_diag_read_arbiter;

   localparam int NR = 4;
   localparam int RW = 7;
   localparam int EW = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          enable;
   logic [NR-1:0] req;
   logic [NR*RW-1:0] req_row;
   logic [NR-1:0] gnt;
   logic [NR-1:0] rsp_valid;
   logic [EW-1:0] rsp_data;
   logic          rsp_err;
   logic          mem_rd_en;
   logic [RW-1:0] mem_addr;
   logic [EW-1:0] mem_rd_data = '0;
   logic          idle;

   int tests_run = 0;
   int fail_cnt  = 0;

   a_diag_read_arbiter #(
      .NUM_REQ(NR), .ROW_WIDTH(RW), .NUM_ROWS(64), .ELEMENT_WIDTH(EW), .MEM_LATENCY(1)
   ) dut (
      .clk(clk), .rst(rst), .enable(enable), .req(req), .req_row(req_row),
      .gnt(gnt), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
      .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data), .idle(idle)
   );

   always #5 clk = ~clk;

   // Diagonal memory: a_ii = 3F800000+i one cycle after the read strobe, junk otherwise.
   always @(posedge clk)
      mem_rd_data <= mem_rd_en ? (32'h3F800000 + 32'(mem_addr)) : 32'hDEADBEEF;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         fail_cnt++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst     = 1'b1;
      enable  = 1'b1;
      req     = 4'b1111;
      req_row = {7'd13, 7'd12, 7'd11, 7'd10};
      repeat (3) @(posedge clk);
      #1;
      check("rst_gnt", 32'(gnt), 0);
      check("rst_rsp_valid", 32'(rsp_valid), 0);
      check("rst_rsp_data", rsp_data, 0);
      check("rst_rsp_err", 32'(rsp_err), 0);
      check("rst_mem_rd_en", 32'(mem_rd_en), 0);
      check("rst_mem_addr", 32'(mem_addr), 0);
      check("rst_idle", 32'(idle), 1);
      rst = 1'b0;

      // Round-robin with all requesters active
      tick;
      check("rr_gnt0", 32'(gnt), 32'b0001);
      check("rr_addr0", 32'(mem_addr), 10);
      check("rr_rden0", 32'(mem_rd_en), 1);
      tick;
      check("rr_gnt1", 32'(gnt), 32'b0010);
      check("rr_addr1", 32'(mem_addr), 11);
      tick;
      check("rr_gnt2", 32'(gnt), 32'b0100);
      check("rr_addr2", 32'(mem_addr), 12);
      check("rr_rsp0_v", 32'(rsp_valid), 32'b0001);
      check("rr_rsp0_d", rsp_data, 32'h3F80000A);
      tick;
      check("rr_gnt3", 32'(gnt), 32'b1000);
      check("rr_rsp1_v", 32'(rsp_valid), 32'b0010);
      check("rr_rsp1_d", rsp_data, 32'h3F80000B);
      tick;
      check("rr_gnt4", 32'(gnt), 32'b0001);
      check("rr_rsp2_v", 32'(rsp_valid), 32'b0100);
      check("rr_rsp2_d", rsp_data, 32'h3F80000C);
      req = 4'b0000;
      tick;
      check("rr_gnt5", 32'(gnt), 0);
      check("rr_rsp3_v", 32'(rsp_valid), 32'b1000);
      check("rr_rsp3_d", rsp_data, 32'h3F80000D);
      tick;
      check("rr_rsp4_v", 32'(rsp_valid), 32'b0001);
      check("rr_rsp4_d", rsp_data, 32'h3F80000A);
      check("rr_busy", 32'(idle), 0);
      tick;
      check("rr_drained_v", 32'(rsp_valid), 0);
      check("rr_idle", 32'(idle), 1);

      // Data return: requester 2 reads row 5
      req_row[2*RW +: RW] = 7'd5;
      req = 4'b0100;
      tick;
      check("dr_gnt", 32'(gnt), 32'b0100);
      check("dr_addr", 32'(mem_addr), 5);
      check("dr_rden", 32'(mem_rd_en), 1);
      req = 4'b0000;
      tick;
      check("dr_g1_v", 32'(rsp_valid), 0);
      tick;
      check("dr_rsp_v", 32'(rsp_valid), 32'b0100);
      check("dr_rsp_d", rsp_data, 32'h3F800005);
      check("dr_rsp_e", 32'(rsp_err), 0);

      // Out of range: requester 1 reads row 64
      req_row[1*RW +: RW] = 7'd64;
      req = 4'b0010;
      tick;
      check("oor_gnt", 32'(gnt), 32'b0010);
      check("oor_rden", 32'(mem_rd_en), 0);
      check("oor_addr_hold", 32'(mem_addr), 5);
      req = 4'b0000;
      tick;
      tick;
      check("oor_rsp_v", 32'(rsp_valid), 32'b0010);
      check("oor_rsp_e", 32'(rsp_err), 1);
      check("oor_rsp_d", rsp_data, 0);

      // Enable low blocks grants but lets the outstanding read finish
      req_row[1*RW +: RW] = 7'd11;
      req_row[0*RW +: RW] = 7'd3;
      req = 4'b0001;
      tick;
      check("en_gnt0", 32'(gnt), 32'b0001);
      check("en_addr0", 32'(mem_addr), 3);
      enable = 1'b0;
      req    = 4'b1110;
      tick;
      check("en_blk1", 32'(gnt), 0);
      tick;
      check("en_blk2", 32'(gnt), 0);
      check("en_rsp_v", 32'(rsp_valid), 32'b0001);
      check("en_rsp_d", rsp_data, 32'h3F800003);
      tick;
      check("en_blk3", 32'(gnt), 0);
      check("en_idle", 32'(idle), 1);
      enable = 1'b1;
      tick;
      check("en_resume", 32'(gnt), 32'b0010);
      check("en_resume_addr", 32'(mem_addr), 11);
      req = 4'b0000;
      tick;
      tick;
      check("en_rsp1_v", 32'(rsp_valid), 32'b0010);
      check("en_rsp1_d", rsp_data, 32'h3F80000B);
      tick;
      check("en_idle2", 32'(idle), 1);

      // Reset while a read is in flight discards it and rewinds the pointer
      req = 4'b0100;
      tick;
      check("mr_gnt", 32'(gnt), 32'b0100);
      req = 4'b0000;
      tick;
      rst = 1'b1;
      #1;
      check("mr_gnt_clr", 32'(gnt), 0);
      check("mr_idle", 32'(idle), 1);
      for (int c = 0; c < 2; c++) begin
         tick;
         check("mr_rsp_in_rst", 32'(rsp_valid), 0);
      end
      rst = 1'b0;
      for (int c = 0; c < 3; c++) begin
         tick;
         check("mr_rsp_after", 32'(rsp_valid), 0);
      end
      req = 4'b1111;
      tick;
      check("mr_ptr0", 32'(gnt), 32'b0001);

      $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
      $finish;
   end

endmodule
